// File: rtl/cpu_pkg.sv
// cpu_pkg: shared immediate-mode encoding and field-width constants
package cpu_pkg;
  typedef enum logic [1:0] {IMM9, IMM12, COND_BR19, BR26} imm_mode_e;
  localparam int IMM9_W = 9;
  localparam int IMM12_W = 12;
  localparam int BR19_W = 19;
  localparam int BR26_W = 26;
  localparam int BR_SHIFT = 2;
endpackage

// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if: request/result handshake bundle for the immediate extender
interface imm_extend_pipe_if #(parameter int DATA_W = 64);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [1:0] mode, mode_out;
  logic [25:0] field;
  logic [DATA_W-1:0] pc, imm, target;
  modport master (
    output in_valid, mode, field, pc, out_ready,
    input in_ready, out_valid, imm, target, mode_out
  );
  modport slave (
    input in_valid, mode, field, pc, out_ready,
    output in_ready, out_valid, imm, target, mode_out
  );
endinterface

// File: rtl/imm_extend_core.sv
// imm_extend_core: combinational immediate extension and PC-relative target
module imm_extend_core
  import cpu_pkg::*;
#(parameter int DATA_W = 64) (
  input imm_mode_e mode,
  input logic [25:0] field,
  input logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] target
);
  // Pick the extension for the mode; only branch modes offset the PC
  always_comb begin
    imm = mode == IMM9 ? DATA_W'(signed'(field[IMM9_W-1:0])) :
          mode == IMM12 ? DATA_W'(field[IMM12_W-1:0]) :
          mode == COND_BR19 ? DATA_W'(signed'(field[BR19_W-1:0])) << BR_SHIFT :
          DATA_W'(signed'(field[BR26_W-1:0])) << BR_SHIFT;
    target = (mode == COND_BR19 || mode == BR26) ? pc + imm : pc;
  end
endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: STAGES-deep registered immediate extender with valid/ready and flush
module imm_extend_pipe
  import cpu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int STAGES = 1
) (
  input logic clk,
  input logic reset,
  input logic flush,
  imm_extend_pipe_if.slave bus
);
  typedef struct packed {
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] target;
    imm_mode_e mode;
  } stage_t;
  stage_t [STAGES-1:0] data_q, data_d;
  logic [STAGES-1:0] valid_q, valid_d;
  logic [DATA_W-1:0] ext_imm, ext_target;
  logic advance;
  imm_extend_core #(.DATA_W(DATA_W)) u_core (
    .mode(imm_mode_e'(bus.mode)),
    .field(bus.field),
    .pc(bus.pc),
    .imm(ext_imm),
    .target(ext_target)
  );
  assign advance = bus.out_ready | ~valid_q[STAGES-1];
  assign bus.in_ready = advance & ~flush;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.imm = data_q[STAGES-1].imm;
  assign bus.target = data_q[STAGES-1].target;
  assign bus.mode_out = data_q[STAGES-1].mode;
  // Whole pipe shifts together when the tail can move; flush kills every valid bit
  always_comb begin
    valid_d = valid_q;
    data_d = data_q;
    if (advance) begin
      valid_d[0] = bus.in_valid & bus.in_ready;
      data_d[0] = '{imm: ext_imm, target: ext_target, mode: imm_mode_e'(bus.mode)};
      for (int i = 1; i < STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
        data_d[i] = data_q[i-1];
      end
    end
    if (flush) valid_d = '0;
  end
  // Stage registers, cleared asynchronously so outputs read zero in reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed checks of extension, latency, stall, flush and reset
module tb_imm_extend_pipe;
  import cpu_pkg::*;
  logic clk = 0, reset = 0, flush1 = 0, flush3 = 0;
  int tests = 0, fails = 0;
  localparam logic [1:0] BR_M [6] = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd3, 2'd2};
  localparam logic [25:0] BR_F [6] = '{26'h007FFFF, 26'h0000010, 26'h0000003, 26'h0000001, 26'h2000000, 26'h3FC0000};
  localparam logic [63:0] BR_PC [6] = '{64'h100, 64'h0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1000_0000, 64'h0010_0000};
  localparam logic [63:0] BR_IMM [6] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 64'hC, 64'h4, 64'hFFFF_FFFF_F800_0000, 64'hFFFF_FFFF_FFF0_0000};
  localparam logic [63:0] BR_TGT [6] = '{64'hFC, 64'h40, 64'h100C, 64'h0, 64'h0800_0000, 64'h0};
  imm_extend_pipe_if #(.DATA_W(64)) b1();
  imm_extend_pipe_if #(.DATA_W(64)) b3();
  imm_extend_pipe #(.DATA_W(64), .STAGES(1)) dut1 (.clk(clk), .reset(reset), .flush(flush1), .bus(b1));
  imm_extend_pipe #(.DATA_W(64), .STAGES(3)) dut3 (.clk(clk), .reset(reset), .flush(flush3), .bus(b3));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 reset = 1;
    #1;
    tests++; if (b1.out_valid !== 1'b0 || b1.imm !== 64'h0 || b1.target !== 64'h0 || b1.mode_out !== 2'd0) begin fails++; $display("FAIL reset_s1: valid=%b imm=%h target=%h mode=%0d, want all zero", b1.out_valid, b1.imm, b1.target, b1.mode_out); end
    tests++; if (b3.out_valid !== 1'b0 || b3.imm !== 64'h0 || b3.target !== 64'h0 || b3.mode_out !== 2'd0) begin fails++; $display("FAIL reset_s3: valid=%b imm=%h target=%h mode=%0d, want all zero", b3.out_valid, b3.imm, b3.target, b3.mode_out); end
    tests++; if (b1.in_ready !== 1'b1 || b3.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b/%b want 1/1", b1.in_ready, b3.in_ready); end
    #1 reset = 0;
  endtask

  task automatic test_imm9;
    b1.in_valid = 1; b1.mode = 2'd0; b1.field = 26'h3FFE1F0; b1.pc = 64'h1234;
    tick();
    b1.in_valid = 0;
    tests++; if (b1.out_valid !== 1'b1) begin fails++; $display("FAIL imm9_valid: got %b want 1", b1.out_valid); end
    tests++; if (b1.imm !== 64'hFFFF_FFFF_FFFF_FFF0) begin fails++; $display("FAIL imm9_imm: got %h want %h", b1.imm, 64'hFFFF_FFFF_FFFF_FFF0); end
    tests++; if (b1.target !== 64'h1234) begin fails++; $display("FAIL imm9_target: got %h want %h", b1.target, 64'h1234); end
    tests++; if (b1.mode_out !== 2'd0) begin fails++; $display("FAIL imm9_mode: got %0d want 0", b1.mode_out); end
    tick();
    tests++; if (b1.out_valid !== 1'b0) begin fails++; $display("FAIL imm9_drain: got valid %b want 0", b1.out_valid); end
  endtask

  task automatic test_imm12;
    b1.in_valid = 1; b1.mode = 2'd1; b1.field = 26'h2ABFFF; b1.pc = 64'h8000_0000_0000_0004;
    tick();
    b1.in_valid = 0;
    tests++; if (b1.out_valid !== 1'b1 || b1.imm !== 64'h0FFF) begin fails++; $display("FAIL imm12_imm: got valid=%b imm=%h want valid=1 imm=%h", b1.out_valid, b1.imm, 64'h0FFF); end
    tests++; if (b1.target !== 64'h8000_0000_0000_0004) begin fails++; $display("FAIL imm12_target: got %h want %h", b1.target, 64'h8000_0000_0000_0004); end
    tests++; if (b1.mode_out !== 2'd1) begin fails++; $display("FAIL imm12_mode: got %0d want 1", b1.mode_out); end
  endtask

  task automatic test_branch;
    for (int i = 0; i < 6; i++) begin
      b1.in_valid = 1; b1.mode = BR_M[i]; b1.field = BR_F[i]; b1.pc = BR_PC[i];
      tick();
      tests++; if (b1.out_valid !== 1'b1 || b1.imm !== BR_IMM[i]) begin fails++; $display("FAIL branch%0d_imm: got valid=%b imm=%h want valid=1 imm=%h", i, b1.out_valid, b1.imm, BR_IMM[i]); end
      tests++; if (b1.target !== BR_TGT[i]) begin fails++; $display("FAIL branch%0d_target: got %h want %h", i, b1.target, BR_TGT[i]); end
      tests++; if (b1.mode_out !== BR_M[i]) begin fails++; $display("FAIL branch%0d_mode: got %0d want %0d", i, b1.mode_out, BR_M[i]); end
    end
    b1.in_valid = 0;
  endtask

  task automatic test_back_to_back;
    b3.out_ready = 1;
    for (int c = 0; c < 9; c++) begin
      int k;
      if (c < 5) begin
        b3.in_valid = 1; b3.mode = 2'd3; b3.field = 26'(c + 1); b3.pc = 64'(c) * 64'h1000;
      end else b3.in_valid = 0;
      #1;
      tests++; if (b3.in_ready !== 1'b1) begin fails++; $display("FAIL b2b%0d_in_ready: got %b want 1", c, b3.in_ready); end
      tick();
      k = c - 2;
      if (k >= 0 && k < 5) begin
        tests++; if (b3.out_valid !== 1'b1 || b3.imm !== 64'(k + 1) * 64'd4 || b3.target !== 64'(k) * 64'h1000 + 64'(k + 1) * 64'd4) begin fails++; $display("FAIL b2b%0d_out: got valid=%b imm=%h target=%h want entry %0d", c, b3.out_valid, b3.imm, b3.target, k); end
      end else begin
        tests++; if (b3.out_valid !== 1'b0) begin fails++; $display("FAIL b2b%0d_idle: got valid %b want 0", c, b3.out_valid); end
      end
    end
  endtask

  task automatic test_stall;
    logic [63:0] exp [3] = '{64'hB2, 64'hC3, 64'hD4};
    b3.out_ready = 0; b3.mode = 2'd1; b3.pc = 64'h500;
    for (int i = 0; i < 3; i++) begin
      b3.in_valid = 1; b3.field = 26'hA1 + 26'(i) * 26'h11;
      tick();
    end
    b3.field = 26'hD4;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (b3.in_ready !== 1'b0) begin fails++; $display("FAIL stall%0d_in_ready: got %b want 0", i, b3.in_ready); end
      tick();
      tests++; if (b3.out_valid !== 1'b1 || b3.imm !== 64'hA1 || b3.target !== 64'h500 || b3.mode_out !== 2'd1) begin fails++; $display("FAIL stall%0d_hold: got valid=%b imm=%h target=%h mode=%0d want 1/a1/500/1", i, b3.out_valid, b3.imm, b3.target, b3.mode_out); end
    end
    b3.out_ready = 1;
    #1;
    tests++; if (b3.in_ready !== 1'b1) begin fails++; $display("FAIL stall_release_in_ready: got %b want 1", b3.in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      b3.in_valid = 0;
      tests++; if (b3.out_valid !== 1'b1 || b3.imm !== exp[i]) begin fails++; $display("FAIL stall_drain%0d: got valid=%b imm=%h want valid=1 imm=%h", i, b3.out_valid, b3.imm, exp[i]); end
    end
    tick();
    tests++; if (b3.out_valid !== 1'b0) begin fails++; $display("FAIL stall_no_dup: got valid %b want 0", b3.out_valid); end
  endtask

  task automatic test_flush;
    b3.out_ready = 1; b3.mode = 2'd0; b3.pc = 64'h0;
    for (int i = 0; i < 2; i++) begin
      b3.in_valid = 1; b3.field = 26'(i + 5);
      tick();
    end
    b3.field = 26'h7; flush3 = 1;
    #1;
    tests++; if (b3.in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready: got %b want 0", b3.in_ready); end
    tick();
    flush3 = 0; b3.in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tests++; if (b3.out_valid !== 1'b0) begin fails++; $display("FAIL flush_empty%0d: got valid=%b imm=%h want valid 0", i, b3.out_valid, b3.imm); end
      tick();
    end
  endtask

  task automatic test_reset_mid_stall;
    b3.out_ready = 0; b3.mode = 2'd3; b3.field = 26'h7; b3.pc = 64'h40;
    b3.in_valid = 1;
    repeat (3) tick();
    b3.in_valid = 0;
    tests++; if (b3.out_valid !== 1'b1 || b3.imm !== 64'h1C || b3.target !== 64'h5C) begin fails++; $display("FAIL rst_stall_full: got valid=%b imm=%h target=%h want 1/1c/5c", b3.out_valid, b3.imm, b3.target); end
    #3 reset = 1;
    #1;
    tests++; if (b3.out_valid !== 1'b0 || b3.imm !== 64'h0 || b3.target !== 64'h0 || b3.mode_out !== 2'd0) begin fails++; $display("FAIL rst_stall_async: got valid=%b imm=%h target=%h mode=%0d want all zero", b3.out_valid, b3.imm, b3.target, b3.mode_out); end
    #2 reset = 0; b3.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (b3.out_valid !== 1'b0) begin fails++; $display("FAIL rst_stall_replay%0d: got valid %b want 0", i, b3.out_valid); end
    end
  endtask

  initial begin
    b1.in_valid = 0; b1.mode = 0; b1.field = 0; b1.pc = 0; b1.out_ready = 1;
    b3.in_valid = 0; b3.mode = 0; b3.field = 0; b3.pc = 0; b3.out_ready = 1;
    test_reset();
    test_imm9();
    test_imm12();
    test_branch();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
